// File: rtl/clock_divider_pkg.sv
// Shared constants and the reset half-period derivation for the clock divider.
package clock_divider_pkg;

    localparam int DEFAULT_SYS_CLK_HZ = 50_000_000;
    localparam int DEFAULT_DIV_W      = 16;
    localparam int MAX_CHANNELS       = 8;
    localparam int DEFAULT_OUT_HZ     = 5_000_000;

    function automatic int default_half(input int sys_clk_hz);
        return sys_clk_hz / (2 * DEFAULT_OUT_HZ);
    endfunction

endpackage

// File: rtl/clock_div_chan.sv
// One divided-clock channel: active/pending half-period, counter, enable/stop handling and tick.
module clock_div_chan
    import clock_divider_pkg::*;
#(
    parameter int DIV_W        = DEFAULT_DIV_W,
    parameter int DEFAULT_HALF = default_half(DEFAULT_SYS_CLK_HZ)
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             en,
    input  logic             resync,
    input  logic             wr,
    input  logic [DIV_W-1:0] div_val,
    output logic             clk_out,
    output logic             tick
);

    localparam logic [DIV_W-1:0] RESET_HALF = DIV_W'(DEFAULT_HALF);
    localparam logic [DIV_W-1:0] ONE        = DIV_W'(1);

    logic [DIV_W-1:0] half_reg;
    logic [DIV_W-1:0] pend_reg;
    logic [DIV_W-1:0] pend_next;
    logic [DIV_W-1:0] cnt_reg;
    logic             clk_out_reg;
    logic             tick_reg;
    logic             at_boundary;

    assign pend_next   = wr ? div_val : pend_reg;
    assign at_boundary = (cnt_reg == half_reg - ONE);

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            half_reg    <= RESET_HALF;
            pend_reg    <= RESET_HALF;
            cnt_reg     <= '0;
            clk_out_reg <= 1'b0;
            tick_reg    <= 1'b0;
        end else begin
            tick_reg <= 1'b0;
            pend_reg <= pend_next;
            if (resync) begin
                // A same-cycle write wins, so the new value shapes the first aligned phase.
                half_reg    <= pend_next;
                cnt_reg     <= '0;
                clk_out_reg <= 1'b0;
            end else if (half_reg == '0) begin
                // Stopped by a zero divisor; a nonzero pending value restarts with a low phase.
                half_reg    <= pend_reg;
                cnt_reg     <= '0;
                clk_out_reg <= 1'b0;
            end else if (!en && !clk_out_reg) begin
                cnt_reg <= '0;
            end else if (at_boundary) begin
                cnt_reg <= '0;
                if (clk_out_reg) begin
                    clk_out_reg <= 1'b0;
                    half_reg    <= pend_reg;
                end else begin
                    clk_out_reg <= 1'b1;
                    tick_reg    <= 1'b1;
                    // A zero divisor only takes effect where the output falls, never while high.
                    if (pend_reg != '0) begin
                        half_reg <= pend_reg;
                    end
                end
            end else begin
                cnt_reg <= cnt_reg + ONE;
            end
        end
    end

    assign clk_out = clk_out_reg;
    assign tick    = tick_reg;

endmodule

// File: rtl/clock_divider.sv
// Multi-channel programmable clock divider: divisor write decode and resync fan-out to channels.
module clock_divider
    import clock_divider_pkg::*;
#(
    parameter int SYS_CLK_HZ   = DEFAULT_SYS_CLK_HZ,
    parameter int CHANNELS     = 2,
    parameter int DIV_W        = DEFAULT_DIV_W,
    parameter int DEFAULT_HALF = default_half(SYS_CLK_HZ)
) (
    input  logic                clk_in,
    input  logic                reset,
    input  logic [CHANNELS-1:0] en,
    input  logic                resync,
    input  logic                div_wr,
    input  logic [2:0]          div_sel,
    input  logic [DIV_W-1:0]    div_val,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick
);

    logic [CHANNELS-1:0] wr_sel;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            // Selects at or above CHANNELS match no channel and are dropped.
            assign wr_sel[gi] = div_wr && (div_sel == 3'(gi));

            clock_div_chan #(
                .DIV_W        (DIV_W),
                .DEFAULT_HALF (DEFAULT_HALF)
            ) u_chan (
                .clk_in  (clk_in),
                .reset   (reset),
                .en      (en[gi]),
                .resync  (resync),
                .wr      (wr_sel[gi]),
                .div_val (div_val),
                .clk_out (clk_out[gi]),
                .tick    (tick[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_clock_divider.sv
// Scoreboard bench for clock_divider: predicted tick cycles are queued per channel and matched as ticks appear.
module tb_clock_divider;

    logic        clk_in  = 1'b0;
    logic        reset   = 1'b1;
    logic [1:0]  en      = 2'b00;
    logic        resync  = 1'b0;
    logic        div_wr  = 1'b0;
    logic [2:0]  div_sel = 3'd0;
    logic [15:0] div_val = 16'd0;
    logic [1:0]  clk_out;
    logic [1:0]  tick;

    clock_divider #(
        .SYS_CLK_HZ   (50_000_000),
        .CHANNELS     (2),
        .DIV_W        (16),
        .DEFAULT_HALF (5)
    ) dut (
        .clk_in  (clk_in),
        .reset   (reset),
        .en      (en),
        .resync  (resync),
        .div_wr  (div_wr),
        .div_sel (div_sel),
        .div_val (div_val),
        .clk_out (clk_out),
        .tick    (tick)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int tests_run    = 0;
    int tests_failed = 0;
    int exp0_q[$];
    int exp1_q[$];
    logic [1:0] prev_clk_out = 2'b00;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end else begin
            $display("[TB] ok   %s: %0d (cycle %0d)", tag, obs, cyc);
        end
    endtask

    task automatic push_ticks(input int ch, input int first, input int period, input int last);
        for (int t = first; t <= last; t += period) begin
            if (ch == 0) exp0_q.push_back(t);
            else         exp1_q.push_back(t);
        end
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk_in);
    endtask

    task automatic write_div(input logic [2:0] sel, input logic [15:0] val);
        div_wr  = 1'b1;
        div_sel = sel;
        div_val = val;
        @(negedge clk_in);
        div_wr  = 1'b0;
    endtask

    // Tick monitor: every tick must be predicted, on time, and coincide with a rising clk_out.
    always @(negedge clk_in) begin
        int exp_cyc;
        for (int ch = 0; ch < 2; ch++) begin
            if (tick[ch]) begin
                check_val($sformatf("ch%0d_tick_on_rise", ch),
                          32'(clk_out[ch] & ~prev_clk_out[ch]), 32'd1);
                if ((ch == 0 && exp0_q.size() == 0) || (ch == 1 && exp1_q.size() == 0)) begin
                    check_val($sformatf("ch%0d_tick_unexpected", ch), 32'(tick[ch]), 32'd0);
                end else begin
                    exp_cyc = (ch == 0) ? exp0_q.pop_front() : exp1_q.pop_front();
                    check_val($sformatf("ch%0d_tick_cycle", ch), cyc, exp_cyc);
                end
            end
        end
        prev_clk_out <= clk_out;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got cycle %0d, expected end before 10000", cyc);
        $fatal(1);
    end

    initial begin
        int t0;
        int r;

        repeat (3) @(negedge clk_in);
        check_val("rst_clk_out", 32'(clk_out), 32'd0);
        check_val("rst_tick", 32'(tick), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk_in);
        check_val("idle_clk_out", 32'(clk_out), 32'd0);

        // Default divide: period 10, first rise 5 cycles after enable.
        t0 = cyc;
        push_ticks(0, t0 + 5, 10, t0 + 25);
        push_ticks(1, t0 + 5, 10, t0 + 45);
        en = 2'b11;
        wait_to(t0 + 4);
        check_val("first_low_phase", 32'(clk_out), 32'd0);
        wait_to(t0 + 5);
        check_val("first_rise", 32'(clk_out), 32'd3);
        wait_to(t0 + 9);
        check_val("high_phase_end", 32'(clk_out), 32'd3);
        wait_to(t0 + 10);
        check_val("first_fall", 32'(clk_out), 32'd0);

        // New divisor mid high phase: current half completes at 5, then period 6.
        wait_to(t0 + 27);
        push_ticks(0, t0 + 33, 6, t0 + 75);
        write_div(3'd0, 16'd3);
        wait_to(t0 + 29);
        check_val("ch0_old_half_holds", 32'(clk_out[0]), 32'd1);
        wait_to(t0 + 30);
        check_val("ch0_old_half_ends", 32'(clk_out[0]), 32'd0);

        // Drop en[1] two cycles into its high phase.
        wait_to(t0 + 47);
        en = 2'b01;
        wait_to(t0 + 49);
        check_val("ch1_high_completes", 32'(clk_out[1]), 32'd1);
        wait_to(t0 + 50);
        check_val("ch1_stopped_low", 32'(clk_out[1]), 32'd0);
        wait_to(t0 + 58);
        check_val("ch1_stays_low", 32'(clk_out[1]), 32'd0);
        wait_to(t0 + 60);
        push_ticks(1, t0 + 65, 10, t0 + 75);
        en = 2'b11;

        // Resync with H0=3, H1=5.
        wait_to(t0 + 80);
        push_ticks(0, t0 + 84, 6, t0 + 96);
        push_ticks(1, t0 + 86, 10, t0 + 96);
        resync = 1'b1;
        @(negedge clk_in);
        resync = 1'b0;
        check_val("resync_clears", 32'(clk_out), 32'd0);

        // Resync together with a write of 7 to ch0.
        wait_to(t0 + 100);
        push_ticks(0, t0 + 108, 14, t0 + 108);
        push_ticks(1, t0 + 106, 10, t0 + 156);
        resync  = 1'b1;
        div_wr  = 1'b1;
        div_sel = 3'd0;
        div_val = 16'd7;
        @(negedge clk_in);
        resync = 1'b0;
        div_wr = 1'b0;
        check_val("resync_wr_clears", 32'(clk_out), 32'd0);

        // Zero divisor stops ch0 at its next falling boundary.
        wait_to(t0 + 110);
        write_div(3'd0, 16'd0);
        wait_to(t0 + 114);
        check_val("ch0_zero_high_holds", 32'(clk_out[0]), 32'd1);
        wait_to(t0 + 115);
        check_val("ch0_zero_stops", 32'(clk_out[0]), 32'd0);
        wait_to(t0 + 125);
        check_val("ch0_zero_stays", 32'(clk_out[0]), 32'd0);

        // Restart at H=1: clk_in/2, then an out-of-range write that must change nothing.
        wait_to(t0 + 126);
        push_ticks(0, t0 + 129, 2, t0 + 157);
        write_div(3'd0, 16'd1);
        wait_to(t0 + 136);
        write_div(3'd5, 16'd9);

        // Asynchronous reset while both outputs are high.
        wait_to(t0 + 157);
        #2;
        reset = 1'b1;
        #1;
        check_val("async_rst_clk_out", 32'(clk_out), 32'd0);
        check_val("async_rst_tick", 32'(tick), 32'd0);
        @(negedge clk_in);
        @(negedge clk_in);
        reset = 1'b0;
        r = cyc;
        push_ticks(0, r + 5, 10, r + 15);
        push_ticks(1, r + 5, 10, r + 15);
        wait_to(r + 4);
        check_val("post_rst_no_pulse", 32'(clk_out), 32'd0);
        wait_to(r + 20);

        check_val("ch0_ticks_left", 32'(exp0_q.size()), 32'd0);
        check_val("ch1_ticks_left", 32'(exp1_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
